// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the fetch stage.
//   NOP          - instruction word loaded on flush/reset
//   IMEM_AW      - instruction memory word-index width
//   IMEM_BYTES   - size of the instruction image in bytes
//   fetch_state_t- fetch FSM state encoding
//   in_image()   - true when a byte address lies inside the image
package mips_pkg;

    localparam logic [31:0] NOP        = 32'h0000_0000;
    localparam int          IMEM_AW    = 6;
    localparam int          IMEM_BYTES = 256;
    localparam int          IMEM_OFF_W = IMEM_AW + 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // Any set bit above the image offset means the address is outside the
    // image; the word index must never be allowed to wrap silently.
    function automatic logic in_image(input logic [31:0] addr);
        return (addr[31:IMEM_OFF_W] == '0);
    endfunction

endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register.
//   clk, rst_n        - clock, asynchronous active-low reset
//   load              - capture instr_d/pc_d/pc_plus4_d and mark valid
//   flush             - invalidate and insert NOP (wins over load)
//   instr_d, pc_d,
//   pc_plus4_d        - next-stage data from fetch
//   valid, instr, pc,
//   pc_plus4          - registered IF/ID contents
// With neither load nor flush the register holds.
module if_id_register
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] instr_d,
    input  logic [DATA_W-1:0] pc_d,
    input  logic [DATA_W-1:0] pc_plus4_d,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_plus4
);

    logic              vld_p1;
    logic [DATA_W-1:0] instr_p1;
    logic [DATA_W-1:0] pc_p1;
    logic [DATA_W-1:0] pc_plus4_p1;

    // IF -> ID stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            instr_p1    <= DATA_W'(NOP);
            pc_p1       <= '0;
            pc_plus4_p1 <= '0;
        end else if (flush) begin
            // The PC fields keep their old values; only valid/instr matter.
            vld_p1   <= 1'b0;
            instr_p1 <= DATA_W'(NOP);
        end else if (load) begin
            vld_p1      <= 1'b1;
            instr_p1    <= instr_d;
            pc_p1       <= pc_d;
            pc_plus4_p1 <= pc_plus4_d;
        end
    end

    assign valid    = vld_p1;
    assign instr    = instr_p1;
    assign pc       = pc_p1;
    assign pc_plus4 = pc_plus4_p1;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, fetch FSM and IF/ID register.
//   clk, rst_n     - clock, asynchronous active-low reset
//   stall          - hold PC and IF/ID
//   redirect,
//   redirect_pc    - taken branch/jump and its byte target
//   imem_addr      - word index into instruction memory (pc_q[7:2])
//   imem_rd        - combinational instruction memory read data
//   if_valid, if_instr, if_pc, if_pc_plus4 - IF/ID contents
//   range_err      - sticky: a fetch was attempted outside the image
//   misalign_err   - sticky: a redirect target had nonzero low bits
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rd,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_plus4,
    output logic               range_err,
    output logic               misalign_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic         load, flush;
    logic         set_range, set_misalign;

    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q[IMEM_OFF_W-1:2];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        load         = 1'b0;
        flush        = 1'b0;
        set_range    = 1'b0;
        set_misalign = redirect && (redirect_pc[1:0] != 2'b00);

        if (redirect) begin
            // Redirect beats stall and escapes FAULT; the target is forced
            // to word alignment and the instruction in flight is killed.
            pc_d    = {redirect_pc[31:2], 2'b00};
            flush   = 1'b1;
            state_d = RUN;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (!stall) begin
                        if (!in_image(pc_q)) begin
                            flush     = 1'b1;
                            set_range = 1'b1;
                            state_d   = FAULT;
                        end else begin
                            load = 1'b1;
                            pc_d = pc_plus4;
                        end
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    // PC / FSM stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            range_err    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (set_range) begin
                range_err <= 1'b1;
            end
            if (set_misalign) begin
                misalign_err <= 1'b1;
            end
        end
    end

    if_id_register #(
        .DATA_W(32)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .flush      (flush),
        .instr_d    (imem_rd),
        .pc_d       (pc_q),
        .pc_plus4_d (pc_plus4),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc),
        .pc_plus4   (if_pc_plus4)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench for instruction_fetch with a
// behavioural instruction memory and an expected-fetch queue.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        range_err;
    logic        misalign_err;

    logic [31:0] mem [64];

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;
    sb_t sb [$];

    int checks;
    int errors;

    instruction_fetch #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc_plus4  (if_pc_plus4),
        .range_err    (range_err),
        .misalign_err (misalign_err)
    );

    assign imem_rd = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_valid",    {31'd0, if_valid},     32'd0);
        chk("rst_instr",    if_instr,              32'd0);
        chk("rst_pc",       if_pc,                 32'd0);
        chk("rst_pc4",      if_pc_plus4,           32'd0);
        chk("rst_range",    {31'd0, range_err},    32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_addr",     {26'd0, imem_addr},    32'd0);
    endtask

    // One unstalled fetch from byte address pc: expectation queued before the
    // edge, popped and compared after it.
    task automatic fetch(input logic [31:0] pc);
        sb_t e;
        chk("fetch_addr", {26'd0, imem_addr}, {26'd0, pc[7:2]});
        sb.push_back('{instr: mem[pc[7:2]], pc: pc});
        step();
        e = sb.pop_front();
        chk("fetch_valid", {31'd0, if_valid}, 32'd1);
        chk("fetch_instr", if_instr, e.instr);
        chk("fetch_pc",    if_pc,    e.pc);
        chk("fetch_pc4",   if_pc_plus4, e.pc + 32'd4);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        mem[0] = 32'h2802_0005;
        mem[1] = 32'h2803_000C;

        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        #12;
        chk_reset_values();
        rst_n = 1'b1;

        // BOOT edge: nothing loaded
        step();
        chk("boot_valid", {31'd0, if_valid}, 32'd0);
        fetch(32'h0);
        chk("first_word", if_instr, 32'h2802_0005);
        fetch(32'h4);
        chk("second_word", if_instr, 32'h2803_000C);
        fetch(32'h8);

        // Stall three cycles at if_pc=0x8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",    if_pc,    32'h8);
            chk("stall_instr", if_instr, mem[2]);
            chk("stall_addr",  {26'd0, imem_addr}, 32'd3);
        end
        stall = 1'b0;
        fetch(32'hC);

        // Redirect under stall
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h44;
        step();
        chk("redir_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_instr", if_instr, 32'd0);
        chk("redir_addr",  {26'd0, imem_addr}, 32'd17);
        chk("redir_nomis", {31'd0, misalign_err}, 32'd0);
        stall = 1'b0;
        redirect = 1'b0;
        fetch(32'h44);

        // Misaligned redirect
        redirect = 1'b1;
        redirect_pc = 32'h46;
        step();
        chk("mis_set",   {31'd0, misalign_err}, 32'd1);
        chk("mis_valid", {31'd0, if_valid}, 32'd0);
        redirect = 1'b0;
        fetch(32'h44);

        // Aligned redirect: misalign stays sticky
        redirect = 1'b1;
        redirect_pc = 32'h80;
        step();
        chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
        redirect = 1'b0;
        for (int a = 32'h80; a <= 32'hFC; a += 4) fetch(32'(a));

        // Falling off the end of the image
        step();
        chk("range_set",   {31'd0, range_err}, 32'd1);
        chk("range_valid", {31'd0, if_valid}, 32'd0);
        chk("range_instr", if_instr, 32'd0);
        chk("range_pcq",   dut.pc_q, 32'h100);
        stall = 1'b1;
        step();
        stall = 1'b0;
        step();
        chk("fault_valid", {31'd0, if_valid}, 32'd0);
        chk("fault_pcq",   dut.pc_q, 32'h100);
        chk("fault_range", {31'd0, range_err}, 32'd1);

        // Redirect out of FAULT
        redirect = 1'b1;
        redirect_pc = 32'h0;
        step();
        chk("unfault_valid", {31'd0, if_valid}, 32'd0);
        redirect = 1'b0;
        fetch(32'h0);
        fetch(32'h4);

        // Return to FAULT, then reset mid-cycle
        redirect = 1'b1;
        redirect_pc = 32'hFC;
        step();
        redirect = 1'b0;
        fetch(32'hFC);
        step();
        chk("refault_range", {31'd0, range_err}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values();
        #2;
        rst_n = 1'b1;
        step();
        chk("boot2_valid", {31'd0, if_valid}, 32'd0);
        fetch(32'h0);
        chk("first_word2", if_instr, 32'h2802_0005);
        fetch(32'h4);
        chk("second_word2", if_instr, 32'h2803_000C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
